// File: rtl/lab2_seq_divider.sv
// lab2_seq_divider: 8-bit by 4-bit restoring divider, one quotient bit per clock
module lab2_sub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = ~a & b;
  assign p = ~(a ^ b);
  assign c[0] = bin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign d = a ^ b ^ c[3:0];
  assign bout = c[4];
endmodule

module lab2_seq_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [7:0] q, q_n;
  logic [3:0] dv, r, r_n, d;
  logic [2:0] count;
  logic [4:0] t;
  logic       bout, qbit, accept;
  assign t = {r, q[7]};
  lab2_sub4 u_sub (.a(t[3:0]), .b(dv), .bin(1'b0), .d(d), .bout(bout));
  assign busy = state == RUN;
  assign done = state == DONE;
  // trial subtraction: a set T[4] means T exceeds Dv, so D is valid mod 16
  always_comb begin
    qbit = t[4] | ~bout;
    r_n = qbit ? d : t[3:0];
    q_n = {q[6:0], qbit};
  end
  // next state: start only counts outside RUN; zero divisor skips straight to DONE
  always_comb begin
    accept = (state != RUN) && start;
    state_n = accept ? ((divisor == 4'd0) ? DONE : RUN)
            : (state == RUN) ? ((count == 3'd7) ? DONE : RUN) : IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // datapath: capture on accept, shift one quotient bit per RUN cycle, load results on the last
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      dv <= '0;
      r <= '0;
      count <= '0;
      quotient <= '0;
      remainder <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      q <= dividend;
      dv <= divisor;
      r <= '0;
      count <= '0;
      quotient <= (divisor == 4'd0) ? 8'hFF : 8'h00;
      remainder <= '0;
      div_zero <= divisor == 4'd0;
    end else if (state == RUN) begin
      q <= q_n;
      r <= r_n;
      count <= count + 3'd1;
      if (count == 3'd7) begin
        quotient <= q_n;
        remainder <= r_n;
      end
    end
  end
endmodule

// File: tb/tb_lab2_seq_divider.sv
// tb_lab2_seq_divider: scoreboard bench for the sequential divider
module tb_lab2_seq_divider;
  logic       clk, rst, start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy, done, div_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic [12:0] sb[$];
  int checks = 0;
  int errors = 0;

  lab2_seq_divider dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] model(input logic [7:0] dd, input logic [3:0] dv);
    return (dv == 4'd0) ? {8'hFF, 4'h0, 1'b1} : {8'(dd / 8'(dv)), 4'(dd % 8'(dv)), 1'b0};
  endfunction

  task automatic issue(input logic [7:0] dd, input logic [3:0] dv, input bit push);
    @(negedge clk);
    start = 1'b1;
    dividend = dd;
    divisor = dv;
    if (push) sb.push_back(model(dd, dv));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_idx, input int exp_busy, input string name, input bit pulse);
    int idx, nb;
    logic [12:0] e;
    idx = 0;
    nb = 0;
    while (!done && idx < 40) begin
      if (busy) nb++;
      @(negedge clk);
      idx++;
      if (pulse) begin
        start = (idx == 2 || idx == 5);
        dividend = 8'hAA;
        divisor = 4'h1;
      end
    end
    if (pulse) start = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s done timeout got %b exp 1", name, done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_with_done got %b exp 0", name, busy); end
    checks++;
    if (idx != exp_idx) begin errors++; $display("FAIL %s latency got %0d exp %0d", name, idx, exp_idx); end
    checks++;
    if (nb != exp_busy) begin errors++; $display("FAIL %s busy_cycles got %0d exp %0d", name, nb, exp_busy); end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty got result %h exp queued entry", name, {quotient, remainder, div_zero});
    end else begin
      e = sb.pop_front();
      if ({quotient, remainder, div_zero} !== e)
        begin errors++; $display("FAIL %s result q/r/dz got %h/%h/%b exp %h/%h/%b", name,
          quotient, remainder, div_zero, e[12:5], e[4:1], e[0]); end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_pulse_width got %b exp 0", name, done); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    dividend = 8'h00;
    divisor = 4'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_zero} !== 15'd0)
      begin errors++; $display("FAIL reset_outputs got %h exp 0", {busy, done, quotient, remainder, div_zero}); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    issue(8'd200, 4'd7, 1'b1);
    wait_done(8, 8, "div_200_7", 1'b0);
  endtask

  task automatic test_corners;
    logic [7:0] dd[5] = '{8'd255, 8'd255, 8'd13, 8'd0, 8'd171};
    logic [3:0] dv[5] = '{4'd1, 4'd15, 4'd15, 4'd9, 4'd8};
    for (int i = 0; i < 5; i++) begin
      issue(dd[i], dv[i], 1'b1);
      wait_done(8, 8, $sformatf("corner_%0d_%0d", dd[i], dv[i]), 1'b0);
    end
  endtask

  task automatic test_div_zero;
    issue(8'd37, 4'd0, 1'b1);
    wait_done(0, 0, "div_37_0", 1'b0);
  endtask

  task automatic test_start_ignored;
    issue(8'd100, 4'd3, 1'b1);
    wait_done(8, 8, "ignore_start_100_3", 1'b1);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd200;
    divisor = 4'd7;
    sb.push_back(model(8'd200, 4'd7));
    @(negedge clk);
    dividend = 8'd99;
    divisor = 4'd10;
    sb.push_back(model(8'd99, 4'd10));
    wait_done(8, 8, "b2b_first", 1'b0);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_gap busy got %b exp 1", busy); end
    wait_done(8, 8, "b2b_second", 1'b0);
  endtask

  task automatic test_reset_mid_run;
    issue(8'd200, 4'd7, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_zero} !== 15'd0)
      begin errors++; $display("FAIL midrun_reset got %h exp 0", {busy, done, quotient, remainder, div_zero}); end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_priority busy/done got %b exp 00", {busy, done}); end
    issue(8'd50, 4'd6, 1'b1);
    wait_done(8, 8, "after_reset_50_6", 1'b0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_corners;
    test_div_zero;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_run;
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  always @(negedge clk) begin
    if (busy && done) begin
      errors++;
      $display("FAIL busy_done_overlap got 11 exp not both");
    end
  end
endmodule
